adder_bist: RTL and testbench
=============================

Name: adder_bist

Overview:
- Built-in self-test controller for the team's combinational adders (half adder at WIDTH=1, ripple adders at wider WIDTH).
- It is the stimulus/response end of the adder interface:
  - generates pseudo-random operands from an LFSR and drives them into the adder under test;
  - samples the returned sum/carry and compares them against an internally computed golden result;
  - reports pass/fail, error count and first failing vector index.
- Synthesisable replacement for simulation-only random-stimulus benches.

Parameters:
- WIDTH, 1, operand width of adder under test; legal range 1..8.
- NUM_VECTORS, 5, vectors applied per run; legal range 1..65535.
- SEED, 16'hACE1, LFSR value loaded at reset and at every accepted start.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- a_out  output  WIDTH  operand A to adder under test.
- b_out  output  WIDTH  operand B to adder under test.
- sum_in  input  WIDTH  sum returned by adder under test.
- carry_in  input  1  carry returned by adder under test.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_count  output  16  mismatches in current/last run; saturates at 16'hFFFF.
- fail_idx  output  16  0-based index of first mismatching vector; 16'hFFFF if none.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values, applied at the clk edge where rst=1:
  - state=IDLE, lfsr=SEED, vec_cnt=0;
  - a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_idx=16'hFFFF.
- Reset mid-run aborts immediately with no done pulse.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Update: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - a_out = lfsr[WIDTH-1:0]; b_out = lfsr[2*WIDTH-1:WIDTH].
  - a_out/b_out are registered and are 0 outside DRIVE/SAMPLE.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - on start=1: lfsr<=SEED, vec_cnt<=0, err_count<=0, fail_idx<=16'hFFFF, pass<=0; go to DRIVE.
  - on start=0: hold; result outputs keep the values from the last run.
- DRIVE (1 cycle):
  - operands from the current lfsr appear on a_out/b_out;
  - golden {carry,sum} = a_out + b_out, computed at WIDTH+1 bits, is registered;
  - go to SAMPLE.
- SAMPLE (1 cycle):
  - operands held stable; compare {carry_in,sum_in} against golden.
  - On mismatch: err_count increments (saturating); if fail_idx==16'hFFFF, fail_idx<=vec_cnt.
  - Then advance lfsr and increment vec_cnt.
  - Go to DONE if vec_cnt+1==NUM_VECTORS, else go to DRIVE.
- DONE (1 cycle):
  - done=1; pass<=(err_count==0), including any mismatch from the final SAMPLE; busy=0; operands=0;
  - go to IDLE.
- Latency: done is high in the cycle after edge 2*NUM_VECTORS+1, counted from the edge that samples start. Each vector takes exactly 2 cycles.
- start asserted while busy or in DONE is ignored; no queuing.
- Adder under test must be combinational with settle time < 1 clk period.

Optional Feature:
- ADDER_BIST_STOP_ON_FAIL_EN defined:
  - the first mismatch in SAMPLE goes directly to DONE;
  - err_count=1, fail_idx=that index, pass=0;
  - remaining vectors are skipped.
- Undefined: all NUM_VECTORS vectors are always applied.

Test Plan:
- WIDTH=1, NUM_VECTORS=5, SEED=16'hACE1, correct half adder, pulse start:
  - vectors (a,b) = (1,0),(1,1),(1,1),(1,1),(0,1) on consecutive DRIVE cycles;
  - done pulses 11 edges after start; pass=1, err_count=0, fail_idx=16'hFFFF.
- Same setup, sum_in stuck at 0 -> err_count=2, fail_idx=0, pass=0.
- Same setup, carry_in stuck at 0 -> err_count=3, fail_idx=1, pass=0.
- Assert rst during the 3rd vector's SAMPLE:
  - next cycle busy=0, a_out=b_out=0, err_count=0, fail_idx=16'hFFFF;
  - no done pulse;
  - a fresh start reproduces the same vector sequence from (1,0).
- start held high through an entire run -> second run begins only after DONE returns to IDLE; results of the first run visible during that IDLE cycle.
- With ADDER_BIST_STOP_ON_FAIL_EN and carry stuck at 0 -> done after 5 edges, err_count=1, fail_idx=1.

Source files
------------

// File: rtl/adder_bist.sv
// Built-in self-test controller for combinational adders.
// Drives LFSR-generated operands into an adder and checks the returned sum and carry
// against a golden result it computes itself. Reports pass/fail, the number of
// mismatches and the index of the first mismatching vector.
// Optional build macro: ADDER_BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module adder_bist #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned NUM_VECTORS = 5,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      fail_idx
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_t;

    localparam logic [15:0] LastIdx = 16'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      vec_cnt_q, vec_cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   golden_q, golden_d;
    logic [15:0]      err_q, err_d;
    logic [15:0]      fail_q, fail_d;
    logic             pass_q, pass_d;

    logic [15:0]      lfsr_next;
    logic             mismatch;
    logic             last_vec;

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign mismatch  = ({carry_in, sum_in} != golden_q);

    // Next-state logic: sequencing, operand generation and result bookkeeping.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        vec_cnt_d = vec_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        golden_d  = golden_q;
        err_d     = err_q;
        fail_d    = fail_q;
        pass_d    = pass_q;
        last_vec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StDrive;
                    lfsr_d    = SEED;
                    vec_cnt_d = '0;
                    err_d     = '0;
                    fail_d    = 16'hFFFF;
                    pass_d    = 1'b0;
                    // Operands are registered, so load them together with the seed.
                    a_d       = SEED[WIDTH-1:0];
                    b_d       = SEED[2*WIDTH-1:WIDTH];
                end
            end
            StDrive: begin
                golden_d = {1'b0, a_q} + {1'b0, b_q};
                state_d  = StSample;
            end
            StSample: begin
                if (mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (fail_q == 16'hFFFF) begin
                        fail_d = vec_cnt_q;
                    end
                end
                lfsr_d    = lfsr_next;
                vec_cnt_d = vec_cnt_q + 16'd1;
                last_vec  = (vec_cnt_q == LastIdx);
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                last_vec  = last_vec || mismatch;
`else
                last_vec  = last_vec;
`endif
                if (last_vec) begin
                    state_d = StDone;
                    a_d     = '0;
                    b_d     = '0;
                end else begin
                    state_d = StDrive;
                    a_d     = lfsr_next[WIDTH-1:0];
                    b_d     = lfsr_next[2*WIDTH-1:WIDTH];
                end
            end
            StDone: begin
                // err_q already holds any mismatch from the final SAMPLE.
                pass_d  = (err_q == 16'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            vec_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            golden_q  <= '0;
            err_q     <= '0;
            fail_q    <= 16'hFFFF;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            vec_cnt_q <= vec_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            golden_q  <= golden_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            pass_q    <= pass_d;
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        a_out     = a_q;
        b_out     = b_q;
        busy      = (state_q == StDrive) || (state_q == StSample);
        done      = (state_q == StDone);
        pass      = pass_q;
        err_count = err_q;
        fail_idx  = fail_q;
    end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist with a fault-injectable half adder model.
// fault_mode: 0 = correct adder, 1 = sum stuck at 0, 2 = carry stuck at 0.
module tb_adder_bist;

    localparam int unsigned WIDTH = 1;
    localparam int unsigned NV    = 5;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum_in;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [15:0]      fail_idx;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0]   dut_a[NV];
    logic [WIDTH-1:0]   dut_b[NV];
    int                 exp_err;
    int                 exp_fail;
    int                 applied;
    logic [WIDTH:0]     add_res;

    adder_bist #(
        .WIDTH      (WIDTH),
        .NUM_VECTORS(NV),
        .SEED       (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_out    (a_out),
        .b_out    (b_out),
        .sum_in   (sum_in),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_idx (fail_idx)
    );

    always #5 clk = ~clk;

    // Adder under test with optional stuck-at faults.
    always_comb begin
        add_res  = {1'b0, a_out} + {1'b0, b_out};
        sum_in   = add_res[WIDTH-1:0];
        carry_in = add_res[WIDTH];
        if (fault_mode == 1) sum_in = '0;
        if (fault_mode == 2) carry_in = 1'b0;
    end

    // Fill the scoreboard with the vectors a run should apply and the expected results.
    task automatic build_expect(input int mode);
        logic [15:0]      l;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   gold;
        logic [WIDTH:0]   obs;
        l = SEED;
        exp_q.delete();
        exp_err  = 0;
        exp_fail = 16'hFFFF;
        applied  = 0;
        for (int i = 0; i < NV; i++) begin
            a    = l[WIDTH-1:0];
            b    = l[2*WIDTH-1:WIDTH];
            gold = {1'b0, a} + {1'b0, b};
            obs  = gold;
            if (mode == 1) obs[WIDTH-1:0] = '0;
            if (mode == 2) obs[WIDTH] = 1'b0;
            exp_q.push_back({b, a});
            applied++;
            if (obs != gold) begin
                exp_err++;
                if (exp_fail == 16'hFFFF) exp_fail = i;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                break;
`endif
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Follow a run from just after the start edge, popping the scoreboard on each vector.
    task automatic run_vectors(input string name);
        int cyc = 0;
        int bcyc = 0;
        int done_cyc = -1;
        logic [2*WIDTH-1:0] cur = '0;
        while (done_cyc < 0 && cyc < 4 * NV + 20) begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                if (bcyc % 2 == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL %s extra_vector got %0d expected none", name, bcyc / 2);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (bcyc / 2 < NV) begin
                        dut_a[bcyc/2] = a_out;
                        dut_b[bcyc/2] = b_out;
                    end
                end
                checks++;
                if ({b_out, a_out} !== cur) begin
                    errors++;
                    $display("FAIL %s operands busy_cycle %0d got b=%h a=%h expected b=%h a=%h",
                             name, bcyc, b_out, a_out, cur[2*WIDTH-1:WIDTH], cur[WIDTH-1:0]);
                end
                bcyc++;
            end
            if (done) begin
                done_cyc = cyc;
                checks++;
                if (busy !== 1'b0 || a_out !== '0 || b_out !== '0) begin
                    errors++;
                    $display("FAIL %s done_cycle_outputs got busy=%b a=%h b=%h expected 0 0 0",
                             name, busy, a_out, b_out);
                end
            end
        end
        checks++;
        if (done_cyc != 2 * applied + 1) begin
            errors++;
            $display("FAIL %s done_latency got %0d expected %0d", name, done_cyc, 2 * applied + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s vectors_missing got %0d left expected 0", name, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pass !== (exp_err == 0) || err_count !== 16'(exp_err) ||
            fail_idx !== 16'(exp_fail)) begin
            errors++;
            $display("FAIL %s results got done=%b pass=%b err=%0d idx=%h expected 0 %b %0d %h",
                     name, done, pass, err_count, fail_idx, (exp_err == 0), exp_err,
                     16'(exp_fail));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'd0 ||
            fail_idx !== 16'hFFFF || a_out !== '0 || b_out !== '0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b pass=%b err=%0d idx=%h a=%h b=%h expected 0 0 0 0 ffff 0 0",
                     busy, done, pass, err_count, fail_idx, a_out, b_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [NV-1:0] ta;
        logic [NV-1:0] tb;
        ta = 5'b01111;
        tb = 5'b11110;
        fault_mode = 0;
        build_expect(0);
        pulse_start();
        run_vectors("basic");
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (dut_a[i] !== ta[i] || dut_b[i] !== tb[i]) begin
                errors++;
                $display("FAIL basic_vector%0d got (%b,%b) expected (%b,%b)",
                         i, dut_a[i], dut_b[i], ta[i], tb[i]);
            end
        end
    endtask

    task automatic test_fault(input string name, input int mode);
        fault_mode = mode;
        build_expect(mode);
        pulse_start();
        run_vectors(name);
        fault_mode = 0;
    endtask

    task automatic test_reset_mid_run();
        bit saw_done = 1'b0;
        fault_mode = 1;
        build_expect(1);
        pulse_start();
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL midrun_before_reset got busy=%b err=%0d expected 1 1", busy, err_count);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || a_out !== '0 || b_out !== '0 || err_count !== 16'd0 ||
            fail_idx !== 16'hFFFF || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_after_reset got busy=%b a=%h b=%h err=%0d idx=%h done=%b expected 0 0 0 0 ffff 0",
                     busy, a_out, b_out, err_count, fail_idx, done);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done got %b expected 0", saw_done);
        end
        fault_mode = 0;
        build_expect(0);
        pulse_start();
        run_vectors("restart");
        checks++;
        if (dut_a[0] !== SEED[0] || dut_b[0] !== SEED[1]) begin
            errors++;
            $display("FAIL restart_first got (%b,%b) expected (%b,%b)",
                     dut_a[0], dut_b[0], SEED[0], SEED[1]);
        end
    endtask

    task automatic test_start_held();
        bit saw_done = 1'b0;
        fault_mode = 0;
        build_expect(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        run_vectors("held");
        // Now in the IDLE cycle between runs.
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap got busy=%b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || a_out !== SEED[WIDTH-1:0] || b_out !== SEED[2*WIDTH-1:WIDTH]) begin
            errors++;
            $display("FAIL held_second_run got busy=%b a=%h b=%h expected 1 %h %h",
                     busy, a_out, b_out, SEED[WIDTH-1:0], SEED[2*WIDTH-1:WIDTH]);
        end
        start = 1'b0;
        for (int i = 0; i < 4 * NV + 10 && !saw_done; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b1) begin
            errors++;
            $display("FAIL held_second_done got %b expected 1", saw_done);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_fault("sum_stuck", 1);
        test_fault("carry_stuck", 2);
        test_reset_mid_run();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
